// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave port among N_MASTERS IOb masters.
// One transaction is outstanding at a time; the slave sees a single-cycle valid pulse.
module iob_rr_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                            clk_i,
   input  logic                            arstn_i,
   input  logic [N_MASTERS-1:0]            m_valid_i,
   input  logic [N_MASTERS*ADDR_W-1:0]     m_address_i,
   input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
   input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
   output logic [DATA_W-1:0]               m_rdata_o,
   output logic [N_MASTERS-1:0]            m_ready_o,
   output logic                            s_valid_o,
   output logic [ADDR_W-1:0]               s_address_o,
   output logic [DATA_W-1:0]               s_wdata_o,
   output logic [DATA_W/8-1:0]             s_wstrb_o,
   input  logic [DATA_W-1:0]               s_rdata_i,
   input  logic                            s_ready_i,
   output logic [N_MASTERS-1:0]            grant_o,
   output logic                            busy_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int PTR_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;

   logic [N_MASTERS-1:0] sel_oh;
   logic                 sel_found;
   logic [PTR_W-1:0]     gidx;
   logic [PTR_W-1:0]     ptr_nxt;
   logic                 busy;
   logic                 done;

   assign busy = (state_q != IDLE);
   // ISSUE and WAIT both complete on s_ready_i; IDLE ignores a stray ready.
   assign done = busy & s_ready_i;

   // Two passes: requesters at or above the pointer first, then the wrapped ones.
   always_comb begin
      sel_found = 1'b0;
      sel_oh    = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (!sel_found && m_valid_i[i] && (i >= int'(ptr_q))) begin
            sel_found = 1'b1;
            sel_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < N_MASTERS; i++) begin
         if (!sel_found && m_valid_i[i] && (i < int'(ptr_q))) begin
            sel_found = 1'b1;
            sel_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (grant_q[i]) gidx = PTR_W'(i);
      end
   end

   assign ptr_nxt = (gidx == PTR_W'(N_MASTERS - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               grant_d = sel_oh;
               state_d = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (s_ready_i) begin
               grant_d = '0;
               ptr_d   = ptr_nxt;
               state_d = IDLE;
            end else begin
               state_d = WAIT;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      s_address_o = '0;
      s_wdata_o   = '0;
      s_wstrb_o   = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (busy && grant_q[i]) begin
            s_address_o = m_address_i[i*ADDR_W +: ADDR_W];
            s_wdata_o   = m_wdata_i[i*DATA_W +: DATA_W];
            s_wstrb_o   = m_wstrb_i[i*STRB_W +: STRB_W];
         end
      end
   end

   assign s_valid_o = (state_q == ISSUE);
   assign busy_o    = busy;
   assign grant_o   = grant_q;
   assign m_ready_o = done ? grant_q : '0;
   assign m_rdata_o = done ? s_rdata_i : '0;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed bench for iob_rr_arbiter with four masters: a transaction table plus
// hand-written reset and protocol-violation sequences.
module tb_iob_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            arstn = 1'b0;
   logic [N-1:0]    m_valid = '0;
   logic [N*AW-1:0] m_address;
   logic [N*DW-1:0] m_wdata;
   logic [N*SW-1:0] m_wstrb;
   logic [DW-1:0]   m_rdata;
   logic [N-1:0]    m_ready;
   logic            s_valid;
   logic [AW-1:0]   s_address;
   logic [DW-1:0]   s_wdata;
   logic [SW-1:0]   s_wstrb;
   logic [DW-1:0]   s_rdata = '0;
   logic            s_ready = 1'b0;
   logic [N-1:0]    grant;
   logic            busy;

   logic [AW-1:0] addr_tab  [N];
   logic [DW-1:0] wdata_tab [N];
   logic [SW-1:0] wstrb_tab [N];

   typedef struct {
      logic [N-1:0] valid;
      int           wcyc;
      logic [DW-1:0] rdata;
      logic [N-1:0] exp_grant;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iob_rr_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i       (clk),
      .arstn_i     (arstn),
      .m_valid_i   (m_valid),
      .m_address_i (m_address),
      .m_wdata_i   (m_wdata),
      .m_wstrb_i   (m_wstrb),
      .m_rdata_o   (m_rdata),
      .m_ready_o   (m_ready),
      .s_valid_o   (s_valid),
      .s_address_o (s_address),
      .s_wdata_o   (s_wdata),
      .s_wstrb_o   (s_wstrb),
      .s_rdata_i   (s_rdata),
      .s_ready_i   (s_ready),
      .grant_o     (grant),
      .busy_o      (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int oh2idx(input logic [N-1:0] oh);
      int r = 0;
      for (int i = 0; i < N; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic chk_idle_outputs(input string nm);
      chk({nm, " s_valid"}, 32'(s_valid), 32'h0);
      chk({nm, " m_ready"}, 32'(m_ready), 32'h0);
      chk({nm, " grant"},   32'(grant),   32'h0);
      chk({nm, " busy"},    32'(busy),    32'h0);
      chk({nm, " s_addr"},  s_address,    32'h0);
      chk({nm, " s_wdata"}, s_wdata,      32'h0);
      chk({nm, " s_wstrb"}, 32'(s_wstrb), 32'h0);
      chk({nm, " m_rdata"}, m_rdata,      32'h0);
   endtask

   // Entered a little after a rising edge with the arbiter in IDLE.
   task automatic run_txn(input logic [N-1:0] vld, input int wcyc, input logic [DW-1:0] rd,
                          input logic [N-1:0] eg, input int n);
      int g;
      g = oh2idx(eg);
      m_valid = vld;
      s_rdata = 32'h5555_AAAA;
      #1;
      chk($sformatf("v%0d idle s_valid", n), 32'(s_valid), 32'h0);
      chk($sformatf("v%0d idle busy", n),    32'(busy),    32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d issue s_valid", n), 32'(s_valid), 32'h1);
      chk($sformatf("v%0d issue grant", n),   32'(grant),   32'(eg));
      chk($sformatf("v%0d issue s_addr", n),  s_address,    addr_tab[g]);
      chk($sformatf("v%0d issue s_wdata", n), s_wdata,      wdata_tab[g]);
      chk($sformatf("v%0d issue s_wstrb", n), 32'(s_wstrb), 32'(wstrb_tab[g]));
      if (wcyc == 0) begin
         s_ready = 1'b1;
         s_rdata = rd;
         #1;
         chk($sformatf("v%0d m_ready", n), 32'(m_ready), 32'(eg));
         chk($sformatf("v%0d m_rdata", n), m_rdata,      rd);
      end else begin
         #1;
         chk($sformatf("v%0d issue m_ready", n), 32'(m_ready), 32'h0);
         chk($sformatf("v%0d issue m_rdata", n), m_rdata,      32'h0);
         for (int w = 1; w <= wcyc; w++) begin
            @(posedge clk); #1;
            if (w == wcyc) begin
               s_ready = 1'b1;
               s_rdata = rd;
               #1;
               chk($sformatf("v%0d m_ready", n),  32'(m_ready), 32'(eg));
               chk($sformatf("v%0d m_rdata", n),  m_rdata,      rd);
               chk($sformatf("v%0d wait s_valid", n), 32'(s_valid), 32'h0);
               chk($sformatf("v%0d wait s_addr", n),  s_address,    addr_tab[g]);
            end else begin
               #1;
               chk($sformatf("v%0d wait%0d m_ready", n, w), 32'(m_ready), 32'h0);
               chk($sformatf("v%0d wait%0d s_valid", n, w), 32'(s_valid), 32'h0);
            end
         end
      end
      @(posedge clk); #1;
      s_ready = 1'b0;
      #1;
      chk($sformatf("v%0d after busy", n),  32'(busy),  32'h0);
      chk($sformatf("v%0d after grant", n), 32'(grant), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      addr_tab  = '{32'h0000_0100, 32'h0000_0024, 32'h0000_0300, 32'hFFFF_FFFC};
      wdata_tab = '{32'hA0A0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'h8000_0003};
      wstrb_tab = '{4'h0, 4'h0, 4'hF, 4'h3};
      for (int i = 0; i < N; i++) begin
         m_address[i*AW +: AW] = addr_tab[i];
         m_wdata[i*DW +: DW]   = wdata_tab[i];
         m_wstrb[i*SW +: SW]   = wstrb_tab[i];
      end

      // pointer trace starts at 0 after reset; each row advances it past its grant
      vecs[0]  = '{4'b0001, 0, 32'h0000_0000, 4'b0001};
      vecs[1]  = '{4'b0010, 3, 32'hDEAD_BEEF, 4'b0010};
      vecs[2]  = '{4'b1111, 1, 32'hC0DE_0002, 4'b0100};
      vecs[3]  = '{4'b1111, 1, 32'hC0DE_0003, 4'b1000};
      vecs[4]  = '{4'b1111, 1, 32'hC0DE_0004, 4'b0001};
      vecs[5]  = '{4'b1111, 1, 32'hC0DE_0005, 4'b0010};
      vecs[6]  = '{4'b1111, 1, 32'hC0DE_0006, 4'b0100};
      vecs[7]  = '{4'b1111, 1, 32'hC0DE_0007, 4'b1000};
      vecs[8]  = '{4'b1111, 1, 32'hC0DE_0008, 4'b0001};
      vecs[9]  = '{4'b1111, 0, 32'hC0DE_0009, 4'b0010};
      vecs[10] = '{4'b1111, 0, 32'hC0DE_000A, 4'b0100};
      vecs[11] = '{4'b0010, 0, 32'hC0DE_000B, 4'b0010};
      vecs[12] = '{4'b1011, 2, 32'hC0DE_000C, 4'b1000};
      vecs[13] = '{4'b0110, 1, 32'hC0DE_000D, 4'b0010};

      // reset held with random activity on the inputs
      arstn = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         m_valid = 4'($urandom);
         s_ready = 1'($urandom);
         s_rdata = $urandom;
         #1;
         chk_idle_outputs($sformatf("reset c%0d", c));
      end
      @(posedge clk); #1;
      m_valid = '0;
      s_ready = 1'b0;
      arstn   = 1'b1;

      for (int k = 0; k < NV; k++)
         run_txn(vecs[k].valid, vecs[k].wcyc, vecs[k].rdata, vecs[k].exp_grant, k);

      // reset during WAIT for master 2 (pointer is 2 here)
      m_valid = 4'b0100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid-wait grant", 32'(grant), 32'h4);
      chk("mid-wait busy",  32'(busy),  32'h1);
      arstn = 1'b0;
      #1;
      chk_idle_outputs("async reset");
      m_valid = '0;
      @(posedge clk); #1;
      arstn   = 1'b1;
      s_ready = 1'b1;
      s_rdata = 32'hBAD0_BAD0;
      #1;
      chk("stray ready m_ready", 32'(m_ready), 32'h0);
      chk("stray ready m_rdata", m_rdata,      32'h0);
      @(posedge clk); #1;
      chk("stray ready busy",    32'(busy),    32'h0);
      chk("stray ready m_ready2", 32'(m_ready), 32'h0);
      s_ready = 1'b0;

      // pointer was cleared by reset, so master 0 wins first
      run_txn(4'b1111, 1, 32'h1234_5678, 4'b0001, 20);

      // granted master drops valid mid-transaction while another one requests
      m_valid = 4'b1000;
      @(posedge clk); #1;
      chk("drop issue grant", 32'(grant), 32'h8);
      m_valid = 4'b0001;
      @(posedge clk); #1;
      chk("drop wait grant", 32'(grant), 32'h8);
      chk("drop wait s_addr", s_address, addr_tab[3]);
      s_ready = 1'b1;
      s_rdata = 32'h0F0F_0F0F;
      #1;
      chk("drop m_ready", 32'(m_ready), 32'h8);
      chk("drop m_rdata", m_rdata,      32'h0F0F_0F0F);
      @(posedge clk); #1;
      s_ready = 1'b0;
      m_valid = '0;
      #1;
      chk("drop after busy", 32'(busy), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
